// File: rtl/sram_ctrl_128x20_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_128x20_if
// Purpose  : Request/response bus between a client and sram_ctrl_128x20.
//            Request side is valid/ready (fire = req_valid && req_ready);
//            response side is valid/ready with read data held until accepted.
// Signals  : req_valid/req_ready/req_wen/req_addr/req_wdata  - request
//            resp_valid/resp_ready/resp_rdata                - read response
// Modports : master (client), slave (controller)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_ctrl_128x20_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 20
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface
`default_nettype wire

// File: rtl/sram_ctrl_128x20.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_128x20
// Purpose  : Request-side controller for a 128x20 single-port SRAM macro
//            (active-low CEB/WEB, 1-cycle read latency). Sweeps INIT_VALUE
//            into every word after reset, converts valid/ready requests into
//            macro strobes and holds read data until the consumer accepts it.
// Ports    : clk_i        - clock, all state on rising edge
//            rst_i        - synchronous active-high reset
//            bus          - request/response bus (slave modport)
//            init_done_o  - sweep finished, requests accepted
//            sram_ceb_o   - macro chip enable (active low)
//            sram_web_o   - macro write enable (active low)
//            sram_a_o     - macro address
//            sram_d_o     - macro write data
//            sram_q_i     - macro read data, valid the cycle after a read
// Revision : 1.0 - initial release
// ============================================================================
module sram_ctrl_128x20 #(
  parameter int                DEPTH      = 128,
  parameter int                ADDR_W     = 7,
  parameter int                DATA_W     = 20,
  parameter int                INIT_EN    = 1,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
  input  wire logic              clk_i,
  input  wire logic              rst_i,
  sram_ctrl_128x20_if.slave      bus,
  output logic                   init_done_o,
  output logic                   sram_ceb_o,
  output logic                   sram_web_o,
  output logic [ADDR_W-1:0]      sram_a_o,
  output logic [DATA_W-1:0]      sram_d_o,
  input  wire logic [DATA_W-1:0] sram_q_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              init_done_q;
  logic              resp_valid_q, resp_valid_d;
  logic              q_fresh_q,    q_fresh_d;
  logic [DATA_W-1:0] hold_q,       hold_d;
  logic [ADDR_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;

  logic in_init;
  logic fire;
  logic rd_fire;

  assign in_init       = (state_q == S_INIT);
  assign bus.req_ready = !in_init && (!resp_valid_q || bus.resp_ready);
  assign fire          = bus.req_valid && bus.req_ready;
  assign rd_fire       = fire && !bus.req_wen;

  // Macro strobes: the sweep owns the macro during INIT; in RUN the macro is
  // touched only on fire, so an undefined Q is never captured. Address and
  // data keep their last driven value while idle to avoid needless toggling.
  always_comb begin
    sram_ceb_o = 1'b1;
    sram_web_o = 1'b1;
    sram_a_o   = a_q;
    sram_d_o   = d_q;
    if (in_init) begin
      sram_ceb_o = 1'b0;
      sram_web_o = 1'b0;
      sram_a_o   = cnt_q;
      sram_d_o   = INIT_VALUE;
    end else if (fire) begin
      sram_ceb_o = 1'b0;
      sram_web_o = !bus.req_wen;
      sram_a_o   = bus.req_addr;
      sram_d_o   = bus.req_wdata;
    end
  end

  // Response path. Q is only valid in the cycle right after the read strobe
  // (q_fresh); it is copied into the hold register at the end of that cycle
  // so stalled data stays stable however long the consumer waits.
  always_comb begin
    resp_valid_d = resp_valid_q;
    if (rd_fire) begin
      resp_valid_d = 1'b1;
    end else if (bus.resp_ready) begin
      resp_valid_d = 1'b0;
    end
    q_fresh_d = rd_fire;
    hold_d    = q_fresh_q ? sram_q_i : hold_q;
  end

  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = q_fresh_q ? sram_q_i : hold_q;
  assign init_done_o    = init_done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= (INIT_EN != 0) ? S_INIT : S_RUN;
      init_done_q  <= (INIT_EN == 0);
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      q_fresh_q    <= 1'b0;
      hold_q       <= '0;
      a_q          <= '0;
      d_q          <= '0;
    end else begin
      a_q          <= sram_a_o;
      d_q          <= sram_d_o;
      resp_valid_q <= resp_valid_d;
      q_fresh_q    <= q_fresh_d;
      hold_q       <= hold_d;
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + ADDR_W'(1);
          if (cnt_q == LAST_ADDR) begin
            state_q     <= S_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_RUN;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl_128x20.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl_128x20
// Purpose  : Self-checking bench for sram_ctrl_128x20. Includes a behavioural
//            macro model whose Q is random except in the cycle after a read.
//            A second instance covers INIT_EN=0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_ctrl_128x20;
  localparam int AW    = 7;
  localparam int DW    = 20;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_ctrl_128x20_if #(.ADDR_W(AW), .DATA_W(DW)) bus0 ();
  sram_ctrl_128x20_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();

  logic          init0, ceb0, web0, init1, ceb1, web1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1, q0;

  sram_ctrl_128x20 #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .INIT_EN(1), .INIT_VALUE('0)) dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0), .init_done_o(init0),
    .sram_ceb_o(ceb0), .sram_web_o(web0), .sram_a_o(a0), .sram_d_o(d0), .sram_q_i(q0)
  );

  sram_ctrl_128x20 #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW), .INIT_EN(0), .INIT_VALUE('0)) dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1), .init_done_o(init1),
    .sram_ceb_o(ceb1), .sram_web_o(web1), .sram_a_o(a1), .sram_d_o(d1), .sram_q_i('0)
  );

  // Macro model: Q is meaningful only in the cycle after a read strobe.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] q_r, junk;
  logic          q_ok = 1'b0;
  always @(posedge clk) begin
    if (!ceb0 && !web0) mem[a0] <= d0;
    if (!ceb0 && web0)  q_r <= mem[a0];
    q_ok <= !ceb0 && web0;
    junk <= DW'($urandom);
  end
  assign q0 = q_ok ? q_r : junk;

  // Scoreboard: shadow memory plus queue of expected read data.
  int            total = 0;
  int            bad   = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] shadow [DEPTH];
  logic [DW-1:0] e;

  always @(negedge clk) begin
    if (!rst && bus0.req_valid && bus0.req_ready) begin
      if (bus0.req_wen) shadow[bus0.req_addr] = bus0.req_wdata;
      else              exp_q.push_back(shadow[bus0.req_addr]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic w, input logic [AW-1:0] ad, input logic [DW-1:0] wd);
    bus0.req_valid = v;
    bus0.req_wen   = w;
    bus0.req_addr  = ad;
    bus0.req_wdata = wd;
  endtask

  // Checks one full sweep starting at the current cycle, then RUN entry.
  task automatic test_sweep(input string tag);
    logic [30:0] act, expv;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      act  = {ceb0, web0, a0, d0, init0, bus0.req_ready};
      expv = {1'b0, 1'b0, 7'(i), 20'h0, 1'b0, 1'b0};
      total++;
      if (act !== expv) begin
        bad++;
        $display("FAIL %s_sweep[%0d] got=%h want=%h", tag, i, act, expv);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if ({init0, bus0.req_ready, ceb0} !== 3'b111) begin
      bad++;
      $display("FAIL %s_init_done got={done,rdy,ceb}=%b want=111", tag, {init0, bus0.req_ready, ceb0});
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
  endtask

  task automatic test_reset();
    drive0(1'b0, 1'b0, '0, '0);
    bus0.resp_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    test_sweep("reset");
    tick();
    // read 0x55 right after the sweep
    drive0(1'b1, 1'b0, 7'h55, '0);
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 1'b1) begin
      bad++; $display("FAIL post_init_ready got=%b want=1", bus0.req_ready);
    end
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL post_init_resp got valid=%b queued=%0d want valid=1", bus0.resp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (bus0.resp_rdata !== e) begin
        bad++; $display("FAIL post_init_data got=%h want=%h", bus0.resp_rdata, e);
      end
    end
    tick();
  endtask

  task automatic test_write_read();
    bus0.resp_ready = 1'b1;
    drive0(1'b1, 1'b1, 7'h10, 20'h5A5A5);
    @(negedge clk);
    total++;
    if ({bus0.req_ready, ceb0, web0, a0, d0} !== {1'b1, 1'b0, 1'b0, 7'h10, 20'h5A5A5}) begin
      bad++; $display("FAIL wr_strobe got={rdy,ceb,web,a,d}=%h", {bus0.req_ready, ceb0, web0, a0, d0});
    end
    tick();
    drive0(1'b1, 1'b0, 7'h10, '0);
    @(negedge clk);
    total++;
    if ({ceb0, web0, a0} !== {1'b0, 1'b1, 7'h10}) begin
      bad++; $display("FAIL rd_strobe got={ceb,web,a}=%h want=%h", {ceb0, web0, a0}, {1'b0, 1'b1, 7'h10});
    end
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL raw_resp got valid=%b queued=%0d want valid=1", bus0.resp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (bus0.resp_rdata !== e) begin
        bad++; $display("FAIL raw_data got=%h want=%h", bus0.resp_rdata, e);
      end
    end
    tick();
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b0) begin
      bad++; $display("FAIL raw_resp_clear got=%b want=0", bus0.resp_valid);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus0.resp_ready = 1'b0;
    drive0(1'b1, 1'b0, 7'h10, '0);
    @(negedge clk);
    total++;
    if (bus0.req_ready !== 1'b1) begin
      bad++; $display("FAIL bp_accept got=%b want=1", bus0.req_ready);
    end
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      e = (exp_q.size() != 0) ? exp_q[0] : 'x;
      total++;
      if ({bus0.resp_valid, bus0.req_ready, ceb0, bus0.resp_rdata} !== {1'b1, 1'b0, 1'b1, e}) begin
        bad++;
        $display("FAIL bp_stall[%0d] got={vld,rdy,ceb}=%b data=%h want=101 data=%h",
                 k, {bus0.resp_valid, bus0.req_ready, ceb0}, bus0.resp_rdata, e);
      end
      tick();
    end
    bus0.resp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL bp_release got valid=%b queued=%0d want valid=1", bus0.resp_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (bus0.resp_rdata !== e) begin
        bad++; $display("FAIL bp_data got=%h want=%h", bus0.resp_rdata, e);
      end
    end
    tick();
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b0) begin
      bad++; $display("FAIL bp_single_hs got=%b want=0", bus0.resp_valid);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    bus0.resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 1'b1, 7'(i), 20'(i + 1));
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive0(1'b1, 1'b0, 7'(k), '0);
      else       drive0(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      if (k < 4) begin
        total++;
        if (bus0.req_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_ready[%0d] got=%b want=1", k, bus0.req_ready);
        end
      end
      if (k > 0) begin
        total++;
        if (bus0.resp_valid !== 1'b1 || exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_resp[%0d] got valid=%b queued=%0d want valid=1", k, bus0.resp_valid, exp_q.size());
        end else begin
          e = exp_q.pop_front();
          if (bus0.resp_rdata !== e) begin
            bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", k, bus0.resp_rdata, e);
          end
        end
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_drain got=%b want=0", bus0.resp_valid);
    end
    tick();
  endtask

  task automatic test_reset_midsweep();
    drive0(1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 60; i++) tick();
    @(negedge clk);
    total++;
    if ({a0, init0} !== {7'd60, 1'b0}) begin
      bad++; $display("FAIL mid_counter got a=%0d done=%b want a=60 done=0", a0, init0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    test_sweep("midreset");
    tick();
  endtask

  task automatic test_reset_resp();
    bus0.resp_ready = 1'b0;
    drive0(1'b1, 1'b0, 7'h01, '0);
    tick();
    drive0(1'b0, 1'b0, '0, '0);
    @(negedge clk);
    total++;
    if (bus0.resp_valid !== 1'b1) begin
      bad++; $display("FAIL rr_pending got=%b want=1", bus0.resp_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    total++;
    if ({bus0.resp_valid, init0} !== 2'b00) begin
      bad++; $display("FAIL rr_dropped got={vld,done}=%b want=00", {bus0.resp_valid, init0});
    end
    bus0.resp_ready = 1'b1;
    tick();
  endtask

  task automatic test_no_init();
    bus1.req_valid  = 1'b0;
    bus1.req_wen    = 1'b0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;
    bus1.resp_ready = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({init1, bus1.req_ready, ceb1, web1} !== 4'b1111) begin
        bad++; $display("FAIL noinit_idle[%0d] got={done,rdy,ceb,web}=%b want=1111", k, {init1, bus1.req_ready, ceb1, web1});
      end
      tick();
    end
    bus1.req_valid = 1'b1;
    bus1.req_wen   = 1'b1;
    bus1.req_addr  = 7'h33;
    bus1.req_wdata = 20'hABCDE;
    @(negedge clk);
    total++;
    if ({ceb1, web1, a1, d1} !== {1'b0, 1'b0, 7'h33, 20'hABCDE}) begin
      bad++; $display("FAIL noinit_fire got={ceb,web,a,d}=%h", {ceb1, web1, a1, d1});
    end
    tick();
    bus1.req_valid = 1'b0;
  endtask

  initial begin
    drive0(1'b0, 1'b0, '0, '0);
    bus0.resp_ready = 1'b1;
    bus1.req_valid  = 1'b0;
    bus1.req_wen    = 1'b0;
    bus1.req_addr   = '0;
    bus1.req_wdata  = '0;
    bus1.resp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_reset_midsweep();
    test_reset_resp();
    test_no_init();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_ctrl_128x20.md
Name: sram_ctrl_128x20

Overview:
- Request-side controller sitting directly upstream of the 128x20 single-port SRAM macro (active-low CEB/WEB, 1-cycle read latency, Q undefined in non-read cycles).
- Converts a valid/ready read/write request port into macro strobes, clears every entry after reset, and holds read data stable until the consumer accepts it.
- Used by cache tag/meta arrays that need deterministic post-reset contents and backpressure-safe read data.

Parameters:
DEPTH, 128, number of words; must match the macro
ADDR_W, 7, address width, log2(DEPTH)
DATA_W, 20, word width
INIT_EN, 1, 1 = zero-fill sweep after reset; 0 = skip the sweep
INIT_VALUE, 0, word written to every entry during the sweep

Ports:
clock  in  1  single clock; all state on the rising edge
reset  in  1  synchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready (fire)
req_wen  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
resp_valid  out  1  read data available
resp_ready  in  1  consumer accepts resp_rdata
resp_rdata  out  DATA_W  read data
init_done  out  1  sweep finished; block is accepting requests
sram_ceb  out  1  macro chip enable, active low
sram_web  out  1  macro write enable, active low
sram_a  out  ADDR_W  macro address
sram_d  out  DATA_W  macro write data
sram_q  in  DATA_W  macro read data; valid only in the cycle after a read strobe

Behaviour:
- States: INIT (sweep active), RUN. Reset -> INIT if INIT_EN=1, else RUN.
- Reset values: init_done=0 (1 when INIT_EN=0), resp_valid=0, hold register=0, sweep counter=0, q_fresh=0.
- INIT: sram_ceb=0, sram_web=0, sram_a=counter, sram_d=INIT_VALUE, one word per cycle. Counter increments each cycle.
  - When counter=DEPTH-1 is written: go to RUN, init_done=1 from the next cycle. Sweep takes exactly DEPTH cycles.
  - req_ready=0 throughout INIT.
- RUN: req_ready = !resp_valid || resp_ready.
- Macro strobes are combinational from the request:
  - On fire: sram_ceb=0, sram_web=!req_wen, sram_a=req_addr, sram_d=req_wdata.
  - Otherwise: sram_ceb=1, sram_web=1, sram_a/sram_d hold last driven value.
- Write fire: no response is generated; resp_valid is unaffected.
- Read fire in cycle T:
  - resp_valid=1 and q_fresh=1 in cycle T+1; resp_rdata=sram_q during T+1.
  - At the end of T+1 the hold register captures sram_q and q_fresh clears.
  - From T+2 onward resp_rdata=hold register, stable until the handshake.
- resp_valid clears on resp_ready unless a new read fires in the same cycle; in that case it stays 1 with fresh data next cycle. Back-to-back reads sustain 1 read per cycle while resp_ready=1.
- Read-after-write to the same address in the next cycle returns the new data; the macro commits the write on the edge.
- The macro is never strobed in a cycle with no fire and no sweep; this guards against undefined Q being consumed.
- resp_rdata is don't-care when resp_valid=0.
- Reset mid-operation (in INIT or RUN):
  - Pending response is dropped (resp_valid=0).
  - Sweep restarts from address 0 when INIT_EN=1; any in-flight macro access is abandoned.

Test Plan:
- Reset 1 cycle, INIT_EN=1 -> sram_ceb=0/web=0 for exactly 128 cycles with sram_a 0..127 and sram_d=0; init_done rises on cycle 129; then read addr 0x55 -> resp_rdata=0x00000.
- Write 0x5A5A5 @0x10, next cycle read @0x10 with resp_ready=1 -> resp_valid the following cycle with resp_rdata=0x5A5A5.
- Read @0x10 with resp_ready=0 for 5 cycles, bench forces sram_q random after the read cycle -> resp_rdata stays 0x5A5A5, req_ready=0, sram_ceb=1 throughout; release resp_ready -> single handshake.
- Writes 0x00001..0x00004 to @0..3, then 4 back-to-back reads with resp_ready=1 -> req_ready held 1, resp_valid high 4 consecutive cycles, data 1,2,3,4 in order.
- Assert reset during sweep at counter=60 -> counter restarts at 0, init_done=0, full 128-cycle sweep repeats; reset with resp_valid=1 -> resp_valid=0 next cycle.
- INIT_EN=0 -> init_done=1 and req_ready=1 in the first cycle after reset; no macro strobe until the first fire.
